// File: rtl/nes_rom_loader_pkg.sv
// Shared types and constants for the iNES image loader.
// The enum, magic word and block sizes describe the iNES file layout.
package nes_rom_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      SKIP,
      PRG,
      CHR,
      DONE,
      ERR
   } state_t;

   // "NES" followed by MS-DOS EOF, first image byte in the top octet
   localparam logic [31:0] INES_MAGIC = 32'h4E45_531A;

   localparam int HDR_LEN     = 16;
   localparam int TRAINER_LEN = 512;
   localparam int PRG_BANK_SZ = 16384;
   localparam int CHR_BANK_SZ = 8192;

   localparam int CFG_PRG32K  = 33;
   localparam int CFG_MIRROR  = 16;

endpackage

// File: rtl/ines_hdr_check.sv
// Combinational header validation: bank-count limits and mapper-0 check,
// plus the derived trainer flag and PRG/CHR payload lengths in bytes.
module ines_hdr_check
   import nes_rom_loader_pkg::*;
#(
   parameter int MAX_PRG_BANKS = 2,
   parameter int MAX_CHR_BANKS = 1
)
(
   input  logic [7:0]  prg_banks,
   input  logic [7:0]  chr_banks,
   input  logic [7:0]  flags6,
   input  logic [7:0]  flags7,
   output logic        valid,
   output logic        trainer,
   output logic [15:0] prg_len,
   output logic [13:0] chr_len
);

   // Mirroring, battery and four-screen bits pass through cfg_out untouched
   logic unused_flags;
   assign unused_flags = ^{flags6[3], flags6[1:0], flags7[3:0]};

   assign valid = (prg_banks != 8'd0)
                && (int'(prg_banks) <= MAX_PRG_BANKS)
                && (int'(chr_banks) <= MAX_CHR_BANKS)
                && (flags6[7:4] == 4'd0)
                && (flags7[7:4] == 4'd0);

   assign trainer = flags6[2];
   assign prg_len = 16'(prg_banks) * 16'(PRG_BANK_SZ);
   assign chr_len = 14'(chr_banks) * 14'(CHR_BANK_SZ);

endmodule

// File: rtl/nes_rom_loader.sv
// Streams an iNES image into the cartridge PRG/CHR RAMs through their write
// ports, owning the cartridge bus (busy_out) for the duration of a load.
module nes_rom_loader
   import nes_rom_loader_pkg::*;
#(
   parameter int MAX_PRG_BANKS = 2,
   parameter int MAX_CHR_BANKS = 1
)
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        start_in,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid_in,
   output logic        byte_ready_out,
   output logic [39:0] cfg_out,
   output logic        cfg_upd_out,
   output logic        prg_nce_out,
   output logic [14:0] prg_a_out,
   output logic        prg_r_nw_out,
   output logic [7:0]  prg_d_out,
   output logic [13:0] chr_a_out,
   output logic        chr_r_nw_out,
   output logic [7:0]  chr_d_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        err_out
);

   state_t      state_reg;
   logic [14:0] idx_reg;
   logic [39:0] hdr_reg;

   logic        accept;
   logic        hdr_valid;
   logic        hdr_trainer;
   logic [15:0] prg_len;
   logic [13:0] chr_len;
   logic [3:0]  magic_hit;
   logic        magic_bad;
   logic        last_prg;
   logic        last_chr;

   assign accept = byte_valid_in & byte_ready_out;

   for (genvar gi = 0; gi < 4; gi++) begin : g_magic
      assign magic_hit[gi] = (byte_in == INES_MAGIC[31-8*gi -: 8]);
   end

   assign magic_bad = (idx_reg < 15'd4) && !magic_hit[idx_reg[1:0]];
   assign last_prg  = ({1'b0, idx_reg} == (prg_len - 16'd1));
   assign last_chr  = (idx_reg == {1'b0, chr_len - 14'd1});

   // hdr_reg holds header bytes 4..8 in cfg_out order
   ines_hdr_check #(
      .MAX_PRG_BANKS (MAX_PRG_BANKS),
      .MAX_CHR_BANKS (MAX_CHR_BANKS)
   ) u_hdr_check (
      .prg_banks (hdr_reg[39:32]),
      .chr_banks (hdr_reg[31:24]),
      .flags6    (hdr_reg[23:16]),
      .flags7    (hdr_reg[15:8]),
      .valid     (hdr_valid),
      .trainer   (hdr_trainer),
      .prg_len   (prg_len),
      .chr_len   (chr_len)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg      <= IDLE;
         idx_reg        <= 15'd0;
         hdr_reg        <= 40'd0;
         byte_ready_out <= 1'b0;
         cfg_out        <= 40'd0;
         cfg_upd_out    <= 1'b0;
         prg_nce_out    <= 1'b1;
         prg_a_out      <= 15'd0;
         prg_r_nw_out   <= 1'b1;
         prg_d_out      <= 8'd0;
         chr_a_out      <= 14'd0;
         chr_r_nw_out   <= 1'b1;
         chr_d_out      <= 8'd0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         cfg_upd_out  <= 1'b0;
         prg_nce_out  <= 1'b1;
         prg_r_nw_out <= 1'b1;
         chr_r_nw_out <= 1'b1;

         // Write strobes follow the accept regardless of a restart, so a
         // byte taken on the same edge as start_in still reaches RAM.
         if (accept && state_reg == PRG) begin
            prg_nce_out  <= 1'b0;
            prg_r_nw_out <= 1'b0;
            prg_a_out    <= idx_reg;
            prg_d_out    <= byte_in;
         end
         if (accept && state_reg == CHR) begin
            chr_r_nw_out <= 1'b0;
            chr_a_out    <= {1'b0, idx_reg[12:0]};
            chr_d_out    <= byte_in;
         end

         if (start_in) begin
            state_reg      <= HDR;
            idx_reg        <= 15'd0;
            byte_ready_out <= 1'b1;
            busy_out       <= 1'b1;
            done_out       <= 1'b0;
            err_out        <= 1'b0;
         end else begin
            case (state_reg)
               HDR: if (accept) begin
                  idx_reg <= idx_reg + 15'd1;
                  for (int i = 0; i < 5; i++) begin
                     if (idx_reg == 15'(i + 4))
                        hdr_reg[39-8*i -: 8] <= byte_in;
                  end
                  if (magic_bad) begin
                     state_reg      <= ERR;
                     err_out        <= 1'b1;
                     busy_out       <= 1'b0;
                     byte_ready_out <= 1'b0;
                  end else if (idx_reg == 15'(HDR_LEN - 1)) begin
                     idx_reg <= 15'd0;
                     if (hdr_valid) begin
                        cfg_out     <= hdr_reg;
                        cfg_upd_out <= 1'b1;
                        state_reg   <= hdr_trainer ? SKIP : PRG;
                     end else begin
                        state_reg      <= ERR;
                        err_out        <= 1'b1;
                        busy_out       <= 1'b0;
                        byte_ready_out <= 1'b0;
                     end
                  end
               end
               SKIP: if (accept) begin
                  if (idx_reg == 15'(TRAINER_LEN - 1)) begin
                     idx_reg   <= 15'd0;
                     state_reg <= PRG;
                  end else begin
                     idx_reg <= idx_reg + 15'd1;
                  end
               end
               PRG: if (accept) begin
                  if (last_prg) begin
                     idx_reg <= 15'd0;
                     if (chr_len != 14'd0) begin
                        state_reg <= CHR;
                     end else begin
                        state_reg      <= DONE;
                        byte_ready_out <= 1'b0;
                     end
                  end else begin
                     idx_reg <= idx_reg + 15'd1;
                  end
               end
               CHR: if (accept) begin
                  if (last_chr) begin
                     idx_reg        <= 15'd0;
                     state_reg      <= DONE;
                     byte_ready_out <= 1'b0;
                  end else begin
                     idx_reg <= idx_reg + 15'd1;
                  end
               end
               DONE: begin
                  done_out  <= 1'b1;
                  busy_out  <= 1'b0;
                  state_reg <= IDLE;
               end
               ERR:     state_reg <= IDLE;
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nes_rom_loader.sv
// Scoreboard bench: the driver pushes the writes and config each accepted
// byte should cause, derived from the image layout; a monitor pops and compares.
`timescale 1ns/1ps
module tb_nes_rom_loader;
   import nes_rom_loader_pkg::*;

   localparam int MAXP    = 2;
   localparam int MAXC    = 1;
   localparam int IMG_MAX = 16 + 512 + 32768 + 8192;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        start_in = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_valid_in = 1'b0;
   logic        byte_ready_out;
   logic [39:0] cfg_out;
   logic        cfg_upd_out;
   logic        prg_nce_out;
   logic [14:0] prg_a_out;
   logic        prg_r_nw_out;
   logic [7:0]  prg_d_out;
   logic [13:0] chr_a_out;
   logic        chr_r_nw_out;
   logic [7:0]  chr_d_out;
   logic        busy_out;
   logic        done_out;
   logic        err_out;

   nes_rom_loader #(.MAX_PRG_BANKS(MAXP), .MAX_CHR_BANKS(MAXC)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
      .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .byte_ready_out(byte_ready_out), .cfg_out(cfg_out),
      .cfg_upd_out(cfg_upd_out), .prg_nce_out(prg_nce_out),
      .prg_a_out(prg_a_out), .prg_r_nw_out(prg_r_nw_out),
      .prg_d_out(prg_d_out), .chr_a_out(chr_a_out),
      .chr_r_nw_out(chr_r_nw_out), .chr_d_out(chr_d_out),
      .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic        is_chr;
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   int          cfg_pulses = 0;
   wr_t         exp_wr_q[$];
   logic [39:0] exp_cfg_q[$];
   logic [39:0] last_cfg = 40'd0;
   logic [7:0]  img [IMG_MAX];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit hdr_ok_model();
      return img[0] == 8'h4E && img[1] == 8'h45 && img[2] == 8'h53 && img[3] == 8'h1A
          && img[4] >= 8'd1 && int'(img[4]) <= MAXP && int'(img[5]) <= MAXC
          && img[6][7:4] == 4'd0 && img[7][7:4] == 4'd0;
   endfunction

   task automatic build_image(input logic [7:0] prg, input logic [7:0] chr,
                              input logic [7:0] f6, input logic [7:0] b8);
      for (int i = 0; i < IMG_MAX; i++) img[i] = 8'($urandom);
      img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
      img[4] = prg; img[5] = chr; img[6] = f6; img[7] = 8'h00; img[8] = b8;
      for (int i = 9; i < 16; i++) img[i] = 8'h00;
   endtask

   // Stream img[first..last]; expectations are pushed at the moment a byte is
   // certain to be taken on the coming rising edge.
   task automatic stream(input int first, input int last, input int gap_pct);
      int  t, pl, cl, w;
      wr_t e;
      t  = img[6][2] ? 512 : 0;
      pl = int'(img[4]) * 16384;
      cl = int'(img[5]) * 8192;
      for (int p = first; p <= last; p++) begin
         @(negedge clk_in);
         if (int'($urandom_range(99)) < gap_pct) begin
            byte_valid_in = 1'b0;
            @(negedge clk_in);
         end
         byte_valid_in = 1'b1;
         byte_in = img[p];
         w = 0;
         while (!byte_ready_out && w < 100) begin
            @(negedge clk_in);
            w++;
         end
         if (!byte_ready_out) begin
            check("ready_timeout", {63'd0, byte_ready_out}, 64'd1);
            byte_valid_in = 1'b0;
            return;
         end
         if (hdr_ok_model()) begin
            if (p == 15) begin
               exp_cfg_q.push_back({img[4], img[5], img[6], img[7], img[8]});
               last_cfg = {img[4], img[5], img[6], img[7], img[8]};
            end else if (p >= 16 + t && p < 16 + t + pl) begin
               e.is_chr = 1'b0; e.addr = 15'(p - 16 - t); e.data = img[p];
               exp_wr_q.push_back(e);
            end else if (p >= 16 + t + pl && p < 16 + t + pl + cl) begin
               e.is_chr = 1'b1; e.addr = 15'(p - 16 - t - pl); e.data = img[p];
               exp_wr_q.push_back(e);
            end
         end
         @(posedge clk_in);
      end
      #1 byte_valid_in = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      check("start_flags", {61'd0, busy_out, done_out, err_out}, 64'b100);
   endtask

   task automatic expect_done(input string name);
      @(negedge clk_in);
      check({name, "_done_early"}, {63'd0, done_out}, 64'd0);
      @(negedge clk_in);
      check({name, "_done_busy"}, {62'd0, done_out, busy_out}, 64'b10);
      check({name, "_writes_left"}, 64'(exp_wr_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_ctrl"}, {56'd0, prg_nce_out, prg_r_nw_out, chr_r_nw_out, byte_ready_out,
            cfg_upd_out, busy_out, done_out, err_out}, 64'b1110_0000);
      check({name, "_bus"}, {19'd0, prg_a_out, prg_d_out, chr_a_out, chr_d_out}, 64'd0);
      check({name, "_cfg"}, {24'd0, cfg_out}, 64'd0);
   endtask

   always @(negedge clk_in) begin
      wr_t e;
      if (rst_n_in) begin
         if (!prg_nce_out || !prg_r_nw_out) begin
            if (exp_wr_q.size() == 0) begin
               check("prg_unexpected", {62'd0, prg_nce_out, prg_r_nw_out}, 64'b11);
            end else begin
               e = exp_wr_q.pop_front();
               check("prg_write", {38'd0, prg_nce_out, prg_r_nw_out, 1'b0, prg_a_out, prg_d_out},
                     {40'd0, e});
            end
         end
         if (!chr_r_nw_out) begin
            if (exp_wr_q.size() == 0) begin
               check("chr_unexpected", {63'd0, chr_r_nw_out}, 64'd1);
            end else begin
               e = exp_wr_q.pop_front();
               check("chr_write", {40'd0, 1'b1, 1'b0, chr_a_out, chr_d_out}, {40'd0, e});
            end
         end
         if (cfg_upd_out) begin
            cfg_pulses++;
            if (exp_cfg_q.size() == 0)
               check("cfg_upd_unexpected", {63'd0, cfg_upd_out}, 64'd0);
            else
               check("cfg_value", {24'd0, cfg_out}, {24'd0, exp_cfg_q.pop_front()});
         end
      end
   end

   initial begin
      #990000;
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      repeat (3) @(negedge clk_in);
      check_reset_values("reset");
      rst_n_in = 1'b1;

      // NROM-128, back-to-back bytes
      build_image(8'd1, 8'd1, 8'h01, 8'h00);
      pulse_start();
      n0 = cfg_pulses;
      stream(0, 16 + 16384 + 8192 - 1, 0);
      expect_done("nrom128");
      check("nrom128_cfg", {24'd0, cfg_out}, 64'h0101010000);
      check("nrom128_pulses", 64'(cfg_pulses - n0), 64'd1);
      $display("load nrom128: 24576 writes streamed");

      // Bytes offered while idle must be refused
      @(negedge clk_in);
      byte_valid_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("idle_ready", {63'd0, byte_ready_out}, 64'd0);
      byte_valid_in = 1'b0;
      $display("idle: offered bytes ignored");

      // NROM-256 with trainer, random valid gaps
      build_image(8'd2, 8'd1, 8'h04, 8'h00);
      pulse_start();
      stream(0, 16 + 512 + 32768 + 8192 - 1, 5);
      expect_done("nrom256");
      check("nrom256_prg32k", {63'd0, cfg_out[CFG_PRG32K]}, 64'd1);
      check("nrom256_mirror", {63'd0, cfg_out[CFG_MIRROR]}, 64'd0);
      $display("load nrom256+trainer: 40960 writes streamed");

      // Bad magic on byte 3
      build_image(8'd1, 8'd1, 8'h01, 8'h00);
      img[3] = 8'h1B;
      pulse_start();
      stream(0, 3, 0);
      @(negedge clk_in);
      check("magic_err_busy", {62'd0, err_out, busy_out}, 64'b10);
      check("magic_cfg_kept", {24'd0, cfg_out}, {24'd0, last_cfg});
      check("magic_ready", {63'd0, byte_ready_out}, 64'd0);
      $display("load bad magic: rejected");

      // Too many PRG banks: rejected only after byte 15
      build_image(8'd3, 8'd1, 8'h00, 8'h00);
      pulse_start();
      stream(0, 14, 0);
      @(negedge clk_in);
      check("prg3_err_early", {63'd0, err_out}, 64'd0);
      stream(15, 15, 0);
      @(negedge clk_in);
      check("prg3_err_busy", {62'd0, err_out, busy_out}, 64'b10);
      $display("load 3 PRG banks: rejected");

      // Mapper nibble 1
      build_image(8'd1, 8'd1, 8'h10, 8'h00);
      pulse_start();
      stream(0, 15, 0);
      @(negedge clk_in);
      check("mapper_err_busy", {62'd0, err_out, busy_out}, 64'b10);
      check("mapper_cfg_kept", {24'd0, cfg_out}, {24'd0, last_cfg});
      $display("load mapper 1: rejected");

      // CHR-RAM image: reset mid-PRG, then restart a second load part way
      build_image(8'd1, 8'd0, 8'h00, 8'h5A);
      pulse_start();
      stream(0, 16 + 999, 0);
      rst_n_in = 1'b0;
      #1;
      check_reset_values("midload_reset");
      check("reset_pending", 64'(exp_wr_q.size()), 64'd1);
      exp_wr_q.delete();
      last_cfg = 40'd0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      $display("load chr-ram: reset after 1000 PRG bytes");

      pulse_start();
      stream(0, 16 + 499, 0);
      pulse_start();
      n0 = cfg_pulses;
      stream(0, 16 + 16384 - 1, 0);
      expect_done("restart");
      check("restart_pulses", 64'(cfg_pulses - n0), 64'd1);
      check("restart_cfg", {24'd0, cfg_out}, 64'h010000005A);
      check("cfg_left", 64'(exp_cfg_q.size()), 64'd0);
      $display("load chr-ram restarted: 16384 writes streamed");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
